// File: rtl/cv32e40p_pkg.sv
// Shared constants and types for the APU tracker: latency-class encodings and
// the write-back address source selector.
package cv32e40p_pkg;

    localparam int APU_LAT_SINGLE = 1;
    localparam logic [31:0] APU_LAT_MULTI = '1;

    typedef enum logic [1:0] {
        RET_NONE   = 2'd0,
        RET_BYPASS = 2'd1,
        RET_QUEUE  = 2'd2
    } apu_ret_e;

endpackage

// File: rtl/cv32e40p_apu_tracker_if.sv
// APU request/response handshake between the tracker (master) and the APU
// interconnect (slave).
interface cv32e40p_apu_tracker_if;
    logic req;
    logic gnt;
    logic rvalid;

    modport master (output req, input gnt, input rvalid);
    modport slave  (input req, output gnt, output rvalid);
endinterface

// File: rtl/cv32e40p_apu_tracker_queue.sv
// In-order return queue: circular buffer of destination addresses with
// per-entry valid/address vectors exposed for dependency comparison.
module cv32e40p_apu_tracker_queue #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  logic [ADDR_W-1:0]             push_addr_i,
    input  logic                          pop_i,
    output logic [CNT_W-1:0]              count_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [ADDR_W-1:0]             head_addr_o,
    output logic [DEPTH-1:0]              head_onehot_o,
    output logic [DEPTH-1:0]              entry_valid_o,
    output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0]             head_reg, head_next;
    logic [PTR_W-1:0]             tail_reg, tail_next;
    logic [CNT_W-1:0]             count_reg, count_next;
    logic [DEPTH-1:0]             valid_reg;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_reg;

    // Explicit compare-and-clear so non-power-of-two depths wrap correctly
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (pop_i)
            head_next = (head_reg == LAST) ? '0 : head_reg + PTR_W'(1);
        if (push_i)
            tail_next = (tail_reg == LAST) ? '0 : tail_reg + PTR_W'(1);
        if (push_i && !pop_i)
            count_next = count_reg + CNT_W'(1);
        else if (pop_i && !push_i)
            count_next = count_reg - CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    valid_reg[gi] <= 1'b0;
                    addr_reg[gi]  <= '0;
                end else begin
                    if (pop_i && head_reg == PTR_W'(gi))
                        valid_reg[gi] <= 1'b0;
                    if (push_i && tail_reg == PTR_W'(gi)) begin
                        valid_reg[gi] <= 1'b1;
                        addr_reg[gi]  <= push_addr_i;
                    end
                end
            end
            assign head_onehot_o[gi] = (head_reg == PTR_W'(gi));
        end
    endgenerate

    assign count_o       = count_reg;
    assign empty_o       = (count_reg == '0);
    assign full_o        = (count_reg == CNT_W'(DEPTH));
    assign head_addr_o   = addr_reg[head_reg];
    assign entry_valid_o = valid_reg;
    assign entry_addr_o  = addr_reg;

endmodule

// File: rtl/cv32e40p_apu_tracker.sv
// APU dispatcher with a configurable-depth in-order return queue; issues the
// APU request and reports stalls, dependencies and write-back addresses.
module cv32e40p_apu_tracker
    import cv32e40p_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int NUM_RREG = 3,
    parameter int NUM_WREG = 2,
    parameter int ADDR_W   = 6,
    parameter int LAT_W    = 2,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             enable_i,
    input  logic [LAT_W-1:0]                 apu_lat_i,
    input  logic [ADDR_W-1:0]                apu_waddr_i,
    input  logic                             is_decoding_i,
    input  logic [NUM_RREG-1:0][ADDR_W-1:0]  read_regs_i,
    input  logic [NUM_RREG-1:0]              read_regs_valid_i,
    input  logic [NUM_WREG-1:0][ADDR_W-1:0]  write_regs_i,
    input  logic [NUM_WREG-1:0]              write_regs_valid_i,
    cv32e40p_apu_tracker_if.master           apu,
    output logic [ADDR_W-1:0]                apu_waddr_o,
    output logic                             apu_multicycle_o,
    output logic                             apu_singlecycle_o,
    output logic                             active_o,
    output logic [CNT_W-1:0]                 occupancy_o,
    output logic                             stall_o,
    output logic                             perf_type_o,
    output logic                             perf_cont_o,
    output logic                             read_dep_o,
    output logic                             read_dep_for_jalr_o,
    output logic                             write_dep_o,
    output logic                             spurious_o
);

    localparam logic [LAT_W-1:0] LAT_MULTI  = APU_LAT_MULTI[LAT_W-1:0];
    localparam logic [LAT_W-1:0] LAT_SINGLE = LAT_W'(APU_LAT_SINGLE);

    logic [CNT_W-1:0]             q_count;
    logic                         q_empty, q_full;
    logic [ADDR_W-1:0]            q_head_addr;
    logic [DEPTH-1:0]             q_head_onehot, q_entry_valid, live_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] q_entry_addr;

    logic [LAT_W-1:0] lat_reg;
    logic             spurious_reg;
    logic             stall_full, stall_type, stall_nack;
    logic             valid_req, returned_req, pend_req, push, pop;
    apu_ret_e         ret_sel;

    always_comb begin
        stall_full   = q_full;
        stall_type   = enable_i & ~q_empty &
                       (apu_lat_i == LAT_MULTI || apu_lat_i == LAT_SINGLE || apu_lat_i < lat_reg);
        valid_req    = enable_i & ~stall_full & ~stall_type;
        stall_nack   = valid_req & ~apu.gnt;
        // A result arriving with an empty queue belongs to the request issued now
        returned_req = valid_req & apu.rvalid & q_empty;
        pend_req     = valid_req & ~returned_req;
        pop          = apu.rvalid & ~q_empty;
        push         = valid_req & apu.gnt & ~returned_req;
        ret_sel      = RET_NONE;
        if (returned_req)
            ret_sel = RET_BYPASS;
        else if (pop)
            ret_sel = RET_QUEUE;
    end

    always_comb begin
        case (ret_sel)
            RET_BYPASS: apu_waddr_o = apu_waddr_i;
            RET_QUEUE:  apu_waddr_o = q_head_addr;
            default:    apu_waddr_o = '0;
        endcase
    end

    cv32e40p_apu_tracker_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push_i        (push),
        .push_addr_i   (apu_waddr_i),
        .pop_i         (pop),
        .count_o       (q_count),
        .empty_o       (q_empty),
        .full_o        (q_full),
        .head_addr_o   (q_head_addr),
        .head_onehot_o (q_head_onehot),
        .entry_valid_o (q_entry_valid),
        .entry_addr_o  (q_entry_addr)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lat_reg      <= '0;
            spurious_reg <= 1'b0;
        end else begin
            if (valid_req)
                lat_reg <= apu_lat_i;
            if (apu.rvalid && q_empty && !valid_req)
                spurious_reg <= 1'b1;
        end
    end

    // The head entry retiring this cycle no longer blocks readers
    assign live_valid = q_entry_valid & ~(pop ? q_head_onehot : '0);

    logic [NUM_RREG-1:0] rd_hit, rd_hit_jalr;
    logic [NUM_WREG-1:0] wr_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RREG; gi++) begin : g_rd
            logic hit, hit_jalr;
            always_comb begin
                hit      = pend_req & (read_regs_i[gi] == apu_waddr_i);
                hit_jalr = enable_i & (read_regs_i[gi] == apu_waddr_i);
                for (int e = 0; e < DEPTH; e++) begin
                    hit      = hit | (live_valid[e] & (read_regs_i[gi] == q_entry_addr[e]));
                    hit_jalr = hit_jalr | (q_entry_valid[e] & (read_regs_i[gi] == q_entry_addr[e]));
                end
            end
            assign rd_hit[gi]      = hit & read_regs_valid_i[gi];
            assign rd_hit_jalr[gi] = hit_jalr & read_regs_valid_i[gi];
        end
        for (gi = 0; gi < NUM_WREG; gi++) begin : g_wr
            logic hit;
            always_comb begin
                hit = pend_req & (write_regs_i[gi] == apu_waddr_i);
                for (int e = 0; e < DEPTH; e++)
                    hit = hit | (live_valid[e] & (write_regs_i[gi] == q_entry_addr[e]));
            end
            assign wr_hit[gi] = hit & write_regs_valid_i[gi];
        end
    endgenerate

    assign apu.req             = valid_req;
    assign stall_o             = stall_full | stall_type | stall_nack;
    assign perf_type_o         = stall_type;
    assign perf_cont_o         = stall_nack;
    assign active_o            = ~q_empty;
    assign occupancy_o         = q_count;
    assign apu_singlecycle_o   = q_empty;
    assign apu_multicycle_o    = (lat_reg == LAT_MULTI);
    assign spurious_o          = spurious_reg;
    assign read_dep_o          = is_decoding_i & (|rd_hit);
    assign read_dep_for_jalr_o = is_decoding_i & (|rd_hit_jalr);
    assign write_dep_o         = is_decoding_i & (|wr_hit);

endmodule
